// File: rtl/aes_core_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_core_arbiter_if
//  Description : Bundles the signals around aes_core_arbiter:
//                - two requester channels (valid/ready, plaintext, key)
//                - one tagged response channel (valid/ready, id, data, err)
//                - the start/done handshake and data buses of the cipher core
//                Modports:
//                - slave  : the arbiter's view
//                - master : the surrounding system's view (requesters,
//                           response consumer and cipher core)
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_core_arbiter_if #(
  parameter int NB = 128
);
  logic          req0_valid;
  logic          req0_ready;
  logic [NB-1:0] req0_plain;
  logic [NB-1:0] req0_key;
  logic          req1_valid;
  logic          req1_ready;
  logic [NB-1:0] req1_plain;
  logic [NB-1:0] req1_key;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [NB-1:0] rsp_data;
  logic          rsp_err;
  logic          core_start;
  logic [NB-1:0] core_plain;
  logic [NB-1:0] core_key;
  logic          core_done;
  logic [NB-1:0] core_cipher;

  modport slave (
    input  req0_valid, req0_plain, req0_key,
    input  req1_valid, req1_plain, req1_key,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  rsp_ready,
    output core_start, core_plain, core_key,
    input  core_done, core_cipher
  );

  modport master (
    output req0_valid, req0_plain, req0_key,
    output req1_valid, req1_plain, req1_key,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output rsp_ready,
    input  core_start, core_plain, core_key,
    output core_done, core_cipher
  );
endinterface
`default_nettype wire

// File: rtl/aes_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : aes_core_arbiter
//  Description : Shares one AES cipher core between two requesters.
//                Round-robin arbitration, one block in flight, and a tagged
//                response channel carrying the ciphertext.
//  Ports       : clk  - clock, rising edge
//                rstn - asynchronous active-low reset
//                bus  - aes_core_arbiter_if.slave. Carries:
//                       - req0_* / req1_* requester channels
//                       - rsp_* response channel
//                       - core_* cipher core handshake
//  Options     : AES_ARB_TIMEOUT_EN - when defined, a TW-bit watchdog aborts
//                a stuck core after TIMEOUT cycles and returns rsp_err=1 with
//                rsp_data=0. When undefined, the core is waited on
//                indefinitely and rsp_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_core_arbiter #(
  parameter int NB      = 128,
  parameter int TIMEOUT = 31,
  parameter int TW      = 5
) (
  input  wire logic          clk,
  input  wire logic          rstn,
  aes_core_arbiter_if.slave  bus
);

  if (2**TW <= TIMEOUT) begin : g_cfg_check
    $error("aes_core_arbiter: TW too narrow to hold TIMEOUT");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_LOW  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_last_grant;   // requester granted most recently
  logic          r_owner;        // requester owning the block in flight
  logic          r_core_start;
  logic [NB-1:0] r_core_plain;
  logic [NB-1:0] r_core_key;
  logic          r_rsp_valid;
  logic          r_rsp_id;
  logic [NB-1:0] r_rsp_data;

  logic          w_win0;
  logic          w_win1;
  logic          w_rdy0;
  logic          w_rdy1;

  // On a tie, the requester that was not granted last time wins.
  assign w_win0 = bus.req0_valid && (!bus.req1_valid ||  r_last_grant);
  assign w_win1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);

  // Accept only when the core reports idle, so a start pulse is never lost.
  assign w_rdy0 = (r_state == S_IDLE) && bus.core_done && w_win0;
  assign w_rdy1 = (r_state == S_IDLE) && bus.core_done && w_win1;

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.core_start = r_core_start;
  assign bus.core_plain = r_core_plain;
  assign bus.core_key   = r_core_key;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_data   = r_rsp_data;

`ifdef AES_ARB_TIMEOUT_EN
  logic [TW-1:0] r_cnt;
  logic          r_rsp_err;
  logic          w_cnt_hit;

  // True on the cycle whose increment would make the counter reach TIMEOUT.
  assign w_cnt_hit   = (r_cnt == TW'(TIMEOUT - 1));
  assign bus.rsp_err = r_rsp_err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_core_start <= 1'b0;
      r_core_plain <= '0;
      r_core_key   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
`ifdef AES_ARB_TIMEOUT_EN
      r_cnt        <= '0;
      r_rsp_err    <= 1'b0;
`endif
    end else begin
      r_core_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rdy0 || w_rdy1) begin
            r_core_plain <= w_rdy1 ? bus.req1_plain : bus.req0_plain;
            r_core_key   <= w_rdy1 ? bus.req1_key   : bus.req0_key;
            r_owner      <= w_rdy1;
            r_last_grant <= w_rdy1;
            r_core_start <= 1'b1;
            r_state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT_LOW;
`ifdef AES_ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        S_WAIT_LOW: begin
`ifdef AES_ARB_TIMEOUT_EN
          r_cnt <= r_cnt + 1'b1;
          if (w_cnt_hit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_id    <= r_owner;
            r_state     <= S_RESP;
          end else
`endif
          if (!bus.core_done) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
`ifdef AES_ARB_TIMEOUT_EN
          r_cnt <= r_cnt + 1'b1;
`endif
          // Completion takes priority over a watchdog hit on the same cycle.
          if (bus.core_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= bus.core_cipher;
            r_rsp_id    <= r_owner;
`ifdef AES_ARB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
            r_state     <= S_RESP;
          end
`ifdef AES_ARB_TIMEOUT_EN
          else if (w_cnt_hit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_id    <= r_owner;
            r_state     <= S_RESP;
          end
`endif
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_core_arbiter
//  Description : Self-checking bench for aes_core_arbiter. Contains a
//                behavioural 10-round cipher core model and drives a table of
//                directed arbitration vectors. Hand-written sequences cover:
//                - response back-pressure
//                - reset while a block is in flight
//                - a hung core (AES_ARB_TIMEOUT_EN selects the expected
//                  outcome)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_core_arbiter;
  localparam int NB = 128;
  localparam logic [NB-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [NB-1:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [NB-1:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct {
    logic          v0;
    logic          v1;
    logic [NB-1:0] p0;
    logic [NB-1:0] k0;
    logic [NB-1:0] p1;
    logic [NB-1:0] k1;
    logic          exp_id;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  logic core_hang = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n_start = 0;
  logic [3:0] core_cnt;

  always #5 clk = ~clk;

  aes_core_arbiter_if #(.NB(NB)) bus ();

  aes_core_arbiter #(.NB(NB), .TIMEOUT(31), .TW(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Known FIPS-197 pair, otherwise a simple stand-in transform.
  function automatic logic [NB-1:0] core_fn(input logic [NB-1:0] p, input logic [NB-1:0] k);
    if (p == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return p ^ {k[63:0], k[127:64]};
  endfunction

  // Core model: done falls on the edge that sees start and rises 11 edges later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.core_done   <= 1'b1;
      bus.core_cipher <= '0;
      core_cnt        <= '0;
    end else if (bus.core_start) begin
      bus.core_done <= 1'b0;
      core_cnt      <= 4'd11;
    end else if (!bus.core_done && !core_hang) begin
      if (core_cnt == 4'd1) begin
        bus.core_done   <= 1'b1;
        bus.core_cipher <= core_fn(bus.core_plain, bus.core_key);
      end else begin
        core_cnt <= core_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.core_start) n_start <= n_start + 1;
  end

  task automatic chk(input string name, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector, check which requester wins, pass the accept edge and
  // withdraw the requests. Returns at #1 after the accept edge.
  task automatic present_and_accept(input vec_t v);
    int w;
    bus.req0_valid = v.v0; bus.req0_plain = v.p0; bus.req0_key = v.k0;
    bus.req1_valid = v.v1; bus.req1_plain = v.p1; bus.req1_key = v.k1;
    w = 0;
    @(negedge clk);
    while (!(bus.req0_ready || bus.req1_ready) && w < 30) begin
      @(negedge clk);
      w++;
    end
    chk("grant_seen", 128'(bus.req0_ready | bus.req1_ready), 128'd1);
    chk("grant_id", 128'(bus.req1_ready), 128'(v.exp_id));
    chk("grant_onehot", 128'(bus.req0_ready & bus.req1_ready), 128'd0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit, output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < limit) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int s0, lat;
    logic [NB-1:0] p, k;
    p  = v.exp_id ? v.p1 : v.p0;
    k  = v.exp_id ? v.k1 : v.k0;
    s0 = n_start;
    present_and_accept(v);
    wait_rsp(100, lat);
    chk("latency", 128'(lat), 128'd13);
    chk("rsp_id", 128'(bus.rsp_id), 128'(v.exp_id));
    chk("rsp_data", bus.rsp_data, core_fn(p, k));
    chk("rsp_err", 128'(bus.rsp_err), 128'd0);
    chk("start_pulses", 128'(n_start - s0), 128'd1);
    chk("core_plain", bus.core_plain, p);
    chk("core_key", bus.core_key, k);
    tick();
    chk("rsp_cleared", 128'(bus.rsp_valid), 128'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int lat, s0;
    logic stable, r1_seen, rsp_seen;
    logic          c_id, c_err;
    logic [NB-1:0] c_data;
    vec_t v;

    vecs[0] = '{1'b1, 1'b1, FIPS_PT, FIPS_KEY, 128'h1111, 128'h2222, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 128'hA5A5, 128'h5A5A_0000_0000_0000_0000_0000_0000_0001, 128'hDEAD_BEEF, 128'hCAFE, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 128'h0F0F_0F0F, 128'h1, 128'hF0F0, 128'h2, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 128'h0, 128'h0, {4{32'h1234_5678}}, {4{32'h8765_4321}}, 1'b1};
    vecs[4] = '{1'b1, 1'b0, {16{8'h3C}}, {16{8'hC3}}, 128'h0, 128'h0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 128'h77, 128'h88, 128'h0, 128'h0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 128'h99, 128'hAA, 128'hBB, 128'hCC, 1'b1};

    rstn = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_plain = '0; bus.req0_key = '0;
    bus.req1_valid = 1'b0; bus.req1_plain = '0; bus.req1_key = '0;
    bus.rsp_ready  = 1'b0;
    repeat (3) tick();
    chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
    chk("rst_rsp_id_err", 128'({bus.rsp_id, bus.rsp_err}), 128'd0);
    chk("rst_rsp_data", bus.rsp_data, 128'd0);
    chk("rst_core_start", 128'(bus.core_start), 128'd0);
    chk("rst_core_bus", bus.core_plain | bus.core_key, 128'd0);
    chk("rst_ready", 128'({bus.req0_ready, bus.req1_ready}), 128'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Table-driven arbitration and datapath vectors, consumer always ready.
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Back-pressure: response held 20 cycles while req1 waits.
    bus.rsp_ready = 1'b0;
    v = '{1'b1, 1'b0, 128'h5555, 128'h6666, 128'h0, 128'h0, 1'b0};
    present_and_accept(v);
    bus.req1_valid = 1'b1; bus.req1_plain = 128'h4242; bus.req1_key = 128'h2424;
    wait_rsp(100, lat);
    chk("bp_latency", 128'(lat), 128'd13);
    c_id = bus.rsp_id; c_data = bus.rsp_data; c_err = bus.rsp_err;
    chk("bp_rsp_data", c_data, core_fn(128'h5555, 128'h6666));
    stable = 1'b1; r1_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(bus.rsp_valid && bus.rsp_id == c_id && bus.rsp_data == c_data && bus.rsp_err == c_err))
        stable = 1'b0;
      r1_seen |= bus.req1_ready;
    end
    chk("bp_stable", 128'(stable), 128'd1);
    chk("bp_req1_blocked", 128'(r1_seen), 128'd0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_rsp_cleared", 128'(bus.rsp_valid), 128'd0);
    chk("bp_req1_ready_idle", 128'(bus.req1_ready), 128'd1);
    tick();
    bus.req1_valid = 1'b0;
    wait_rsp(100, lat);
    chk("bp_req1_latency", 128'(lat), 128'd13);
    chk("bp_req1_id", 128'(bus.rsp_id), 128'd1);
    chk("bp_req1_data", bus.rsp_data, core_fn(128'h4242, 128'h2424));
    tick();

    // Reset five cycles after accept: everything clears at once, no response.
    v = '{1'b1, 1'b0, 128'hABCD, 128'hEF01, 128'h0, 128'h0, 1'b0};
    present_and_accept(v);
    repeat (5) tick();
    rstn = 1'b0;
    #1;
    chk("mid_rst_rsp", 128'({bus.rsp_valid, bus.rsp_id, bus.rsp_err}), 128'd0);
    chk("mid_rst_rsp_data", bus.rsp_data, 128'd0);
    chk("mid_rst_core_bus", bus.core_plain | bus.core_key, 128'd0);
    chk("mid_rst_start_ready", 128'({bus.core_start, bus.req0_ready, bus.req1_ready}), 128'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rsp_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      rsp_seen |= bus.rsp_valid;
    end
    chk("mid_rst_no_rsp", 128'(rsp_seen), 128'd0);
    v = '{1'b0, 1'b1, 128'h0, 128'h0, 128'h1357, 128'h2468, 1'b1};
    run_vec(v);

    // Hung core.
    core_hang = 1'b1;
    s0 = n_start;
    v = '{1'b1, 1'b0, 128'hFEED, 128'hFACE, 128'h0, 128'h0, 1'b0};
    present_and_accept(v);
`ifdef AES_ARB_TIMEOUT_EN
    wait_rsp(100, lat);
    chk("to_latency", 128'(lat), 128'd32);
    chk("to_rsp_err", 128'(bus.rsp_err), 128'd1);
    chk("to_rsp_data", bus.rsp_data, 128'd0);
    chk("to_rsp_id", 128'(bus.rsp_id), 128'd0);
    tick();
    chk("to_rsp_cleared", 128'(bus.rsp_valid), 128'd0);
    core_hang = 1'b0;
    repeat (20) tick();
`else
    wait_rsp(60, lat);
    chk("hang_no_rsp", 128'(bus.rsp_valid), 128'd0);
    core_hang = 1'b0;
    wait_rsp(50, lat);
    chk("hang_release_rsp", 128'(bus.rsp_valid), 128'd1);
    chk("hang_release_data", bus.rsp_data, core_fn(128'hFEED, 128'hFACE));
    tick();
`endif
    chk("hang_start_pulses", 128'(n_start - s0), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end
endmodule
`default_nettype wire
